// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and controller state type.
package sha256_pkg;

  localparam int unsigned ROUNDS       = 64;
  localparam int unsigned IDX_W        = 6;
  localparam int unsigned SCHED_DIRECT = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_t;

  // Round constants K[0..63], consumed by the datapath.
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Initial hash value H0..H7.
  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_round_counter.sv
// Round index counter: clear, enable, terminal count at ROUNDS-1, saturating.
module sha256_round_counter
  import sha256_pkg::*;
#(
  parameter int unsigned P_ROUNDS = ROUNDS,
  parameter int unsigned P_IDX_W  = IDX_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               i_clr,
  input  logic               i_en,
  output logic [P_IDX_W-1:0] o_cnt,
  output logic               o_tc
);

  logic [P_IDX_W-1:0] r_cnt;
  logic               w_tc;

  assign w_tc  = (r_cnt == P_IDX_W'(P_ROUNDS - 1));
  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

  // Count up while enabled; hold at terminal count instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression control FSM: block handshake, 64-round sequencing,
// hash update pulse and digest-valid handshake. No datapath storage here.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned P_ROUNDS       = ROUNDS,
  parameter int unsigned P_IDX_W        = IDX_W,
  parameter int unsigned P_SCHED_DIRECT = SCHED_DIRECT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               blk_valid_i,
  input  logic               blk_first_i,
  input  logic               blk_last_i,
  output logic               blk_ready_o,
  output logic               load_iv_o,
  output logic               load_blk_o,
  output logic               round_en_o,
  output logic [P_IDX_W-1:0] round_idx_o,
  output logic               w_sel_o,
  output logic               upd_hash_o,
  output logic               busy_o,
  output logic               dig_valid_o,
  input  logic               dig_ack_i
);

  state_t             r_state;
  state_t             w_next;
  logic               r_first;
  logic               r_last;
  logic               w_accept;
  logic [P_IDX_W-1:0] w_cnt;
  logic               w_tc;

  assign w_accept = (r_state == S_IDLE) && blk_valid_i;

  sha256_round_counter #(
    .P_ROUNDS (P_ROUNDS),
    .P_IDX_W  (P_IDX_W)
  ) u_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .i_clr (r_state == S_LOAD),
    .i_en  (r_state == S_ROUND),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture block qualifiers at accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_first <= blk_first_i;
      r_last  <= blk_last_i;
    end
  end

  // Next-state and output decode from registered state and counter only.
  always_comb begin
    w_next      = r_state;
    blk_ready_o = 1'b0;
    load_iv_o   = 1'b0;
    load_blk_o  = 1'b0;
    round_en_o  = 1'b0;
    round_idx_o = '0;
    w_sel_o     = 1'b0;
    upd_hash_o  = 1'b0;
    busy_o      = 1'b1;
    dig_valid_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        blk_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (blk_valid_i) w_next = S_LOAD;
      end
      S_LOAD: begin
        load_blk_o = 1'b1;
        load_iv_o  = r_first;
        w_next     = S_ROUND;
      end
      S_ROUND: begin
        round_en_o  = 1'b1;
        round_idx_o = w_cnt;
        w_sel_o     = (w_cnt < P_IDX_W'(P_SCHED_DIRECT));
        if (w_tc) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        upd_hash_o = 1'b1;
        w_next     = r_last ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        dig_valid_o = 1'b1;
        if (dig_ack_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: cycle-accurate latency model, a behavioural
// SHA-256 datapath driven by the controller outputs, and directed scenarios.
module tb_sha256_round_ctrl;
  import sha256_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       blk_valid_i = 1'b0;
  logic       blk_first_i = 1'b0;
  logic       blk_last_i = 1'b0;
  logic       dig_ack_i = 1'b0;
  logic       blk_ready_o, load_iv_o, load_blk_o, round_en_o, w_sel_o;
  logic       upd_hash_o, busy_o, dig_valid_o;
  logic [5:0] round_idx_o;

  sha256_round_ctrl #(.P_ROUNDS(64), .P_IDX_W(6), .P_SCHED_DIRECT(16)) dut (
    .CLK(CLK), .RST(RST), .blk_valid_i(blk_valid_i), .blk_first_i(blk_first_i),
    .blk_last_i(blk_last_i), .blk_ready_o(blk_ready_o), .load_iv_o(load_iv_o),
    .load_blk_o(load_blk_o), .round_en_o(round_en_o), .round_idx_o(round_idx_o),
    .w_sel_o(w_sel_o), .upd_hash_o(upd_hash_o), .busy_o(busy_o),
    .dig_valid_o(dig_valid_o), .dig_ack_i(dig_ack_i)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- latency model: cycles since accept ----------------
  bit m_on = 0;
  int m_t = -1;       // -1: not processing a block; k: k-th cycle after accept
  bit m_done = 0;     // digest presented, awaiting ack
  bit m_first = 0;
  bit m_last = 0;

  always @(posedge CLK) begin
    if (RST) begin
      m_on = 1; m_t = -1; m_done = 0; m_first = 0; m_last = 0;
    end else if (m_done) begin
      if (dig_ack_i) m_done = 0;
    end else if (m_t < 0) begin
      if (blk_valid_i) begin
        m_t = 1; m_first = blk_first_i; m_last = blk_last_i;
      end
    end else if (m_t == 66) begin
      m_t = -1; m_done = m_last;
    end else begin
      m_t++;
    end
  end

  always @(negedge CLK) begin
    if (m_on) begin
      bit e_idle, e_round;
      e_idle  = (m_t < 0) && !m_done;
      e_round = (m_t >= 2) && (m_t <= 65);
      chk("blk_ready", blk_ready_o, e_idle);
      chk("busy", busy_o, !e_idle);
      chk("load_blk", load_blk_o, m_t == 1);
      chk("load_iv", load_iv_o, (m_t == 1) && m_first);
      chk("round_en", round_en_o, e_round);
      chk("round_idx", round_idx_o, e_round ? m_t - 2 : 0);
      chk("w_sel", w_sel_o, e_round && (m_t - 2 < 16));
      chk("upd_hash", upd_hash_o, m_t == 66);
      chk("dig_valid", dig_valid_o, m_done);
    end
  end

  // ---------------- behavioural datapath ----------------
  bit [31:0] blk [16];
  bit [31:0] W [64];
  bit [31:0] H [8];
  bit [31:0] wk [8];

  function automatic bit [31:0] rotr(input bit [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  always @(posedge CLK) begin
    bit [31:0] wt, t1, t2, s0, s1;
    int t;
    if (load_blk_o) begin
      if (load_iv_o) for (int i = 0; i < 8; i++) H[i] = IV[i];
      for (int i = 0; i < 8; i++) wk[i] = H[i];
      for (int i = 0; i < 16; i++) W[i] = blk[i];
    end
    if (round_en_o) begin
      t = int'(round_idx_o);
      if (!w_sel_o && t >= 16) begin
        s0 = rotr(W[t-15], 7) ^ rotr(W[t-15], 18) ^ (W[t-15] >> 3);
        s1 = rotr(W[t-2], 17) ^ rotr(W[t-2], 19) ^ (W[t-2] >> 10);
        W[t] = s1 + W[t-7] + s0 + W[t-16];
      end
      wt = W[t];
      t1 = wk[7] + (rotr(wk[4], 6) ^ rotr(wk[4], 11) ^ rotr(wk[4], 25))
         + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K[t] + wt;
      t2 = (rotr(wk[0], 2) ^ rotr(wk[0], 13) ^ rotr(wk[0], 22))
         + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
      for (int i = 7; i > 0; i--) wk[i] = wk[i-1];
      wk[4] = wk[4] + t1;
      wk[0] = t1 + t2;
    end
    if (upd_hash_o) for (int i = 0; i < 8; i++) H[i] = H[i] + wk[i];
  end

  function automatic logic [255:0] digest();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[255 - 32*i -: 32] = H[i];
    return d;
  endfunction

  task automatic set_block(input logic [511:0] v);
    for (int i = 0; i < 16; i++) blk[i] = v[511 - 32*i -: 32];
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready();
    int i;
    i = 0;
    while (!blk_ready_o && i < 200) begin @(negedge CLK); i++; end
    chk("wait_ready_timeout", blk_ready_o, 1'b1);
  endtask

  // Leaves the bench at the negedge of the LOAD cycle, valid dropped.
  task automatic start_block(input bit first, input bit last);
    wait_ready();
    blk_valid_i = 1'b1; blk_first_i = first; blk_last_i = last;
    @(posedge CLK);
    @(negedge CLK);
    blk_valid_i = 1'b0; blk_first_i = 1'b0; blk_last_i = 1'b0;
  endtask

  // Runs to the UPDATE cycle and checks accept-to-update latency.
  task automatic finish_block();
    int cyc;
    cyc = 1;
    while (!upd_hash_o && cyc < 120) begin @(negedge CLK); cyc++; end
    chk("upd_latency", cyc, 66);
  endtask

  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_2A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_2 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    // Reset and idle.
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ready", blk_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_pulses", {load_iv_o, load_blk_o, round_en_o, upd_hash_o, dig_valid_o}, 5'b0);

    // Single block "abc" with 10 cycles of digest backpressure.
    set_block(BLK_ABC);
    start_block(1'b1, 1'b1);
    chk("abc_load_iv", load_iv_o, 1'b1);
    finish_block();
    @(negedge CLK);
    chk("abc_dig_valid", dig_valid_o, 1'b1);
    chk("abc_digest", digest(), DIG_ABC);
    repeat (10) begin
      @(negedge CLK);
      chk("bp_hold_valid", dig_valid_o, 1'b1);
      chk("bp_not_ready", blk_ready_o, 1'b0);
    end
    dig_ack_i = 1'b1;
    @(negedge CLK);
    dig_ack_i = 1'b0;
    chk("ack_to_idle", blk_ready_o, 1'b1);

    // Two-block message; ack in the first DONE cycle.
    set_block(BLK_2A);
    start_block(1'b1, 1'b0);
    finish_block();
    @(negedge CLK);
    chk("blk1_ready", blk_ready_o, 1'b1);
    chk("blk1_no_dig", dig_valid_o, 1'b0);
    set_block(BLK_2B);
    start_block(1'b0, 1'b1);
    chk("blk2_no_iv", load_iv_o, 1'b0);
    finish_block();
    @(negedge CLK);
    chk("blk2_dig_valid", dig_valid_o, 1'b1);
    chk("two_block_digest", digest(), DIG_2);
    dig_ack_i = 1'b1;
    @(negedge CLK);
    dig_ack_i = 1'b0;
    chk("one_cycle_dig", dig_valid_o, 1'b0);
    chk("one_cycle_ready", blk_ready_o, 1'b1);

    // Valid held high: one accept per 67 cycles.
    blk_valid_i = 1'b1; blk_first_i = 1'b1; blk_last_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK);
      if (load_blk_o) cnt++;
    end
    blk_valid_i = 1'b0; blk_first_i = 1'b0;
    chk("held_valid_loads", cnt, 3);
    wait_ready();

    // Reset mid-ROUND for 3 cycles.
    set_block(BLK_ABC);
    start_block(1'b1, 1'b1);
    repeat (20) @(negedge CLK);
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_round_ready", blk_ready_o, 1'b1);
      chk("rst_round_upd", upd_hash_o, 1'b0);
    end
    RST = 1'b0;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (upd_hash_o || dig_valid_o) cnt++;
    end
    chk("rst_round_no_upd", cnt, 0);

    // Reset mid-DONE.
    start_block(1'b1, 1'b1);
    finish_block();
    @(negedge CLK);
    chk("pre_rst_dig", dig_valid_o, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_done_dig", dig_valid_o, 1'b0);
    chk("rst_done_ready", blk_ready_o, 1'b1);
    repeat (3) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
